// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
//   sb_entry_t   : one buffered store {addr, is_byte, data}
//   SB_WORD_MASK : byte-enable mask of a full word access
//   byte_mask()  : byte-enable mask of an access from its size and low address bits
package store_buffer_pkg;

  localparam int unsigned SB_DW = 32;
  localparam logic [3:0] SB_WORD_MASK = 4'hF;

  typedef struct packed {
    logic [SB_DW-1:0] addr;
    logic             is_byte;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [3:0] byte_mask(input logic is_byte, input logic [1:0] off);
    return is_byte ? (4'b0001 << off) : SB_WORD_MASK;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular storage for the store buffer.
//   push_i/push_entry_i : enqueue at tail on the rising edge
//   pop_i               : retire head on the rising edge (push and pop may coincide)
//   head_o              : oldest entry
//   entries_o/tail_o    : raw storage and tail pointer for the forwarding CAM
//   count_o/full_o/empty_o : occupancy
// Caller guarantees no push when full without a pop, and no pop when empty.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  sb_entry_t       push_entry_i,
  input  logic            pop_i,
  output sb_entry_t       head_o,
  output sb_entry_t       entries_o [Depth],
  output logic [PtrW-1:0] tail_o,
  output logic [PtrW:0]   count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;
  sb_entry_t       mem_q [Depth];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_i};
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: entries are only observed below count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_o    = mem_q[head_q];
  assign entries_o = mem_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == (PtrW+1)'(Depth));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the MEM stage and data_memory.
//   req_*       : MEM-stage request (store or load); req_ready_o=0 stalls MEM
//   rd_o        : load data (forwarded from the buffer or passed through from memory)
//   empty_o     : no buffered stores
//   mem_*       : shared data_memory port; drains one store per cycle when no load needs it
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic                  req_byte_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wd_i,
  output logic                  req_ready_o,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  empty_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  sb_entry_t       head, push_entry;
  sb_entry_t       entries [DEPTH];
  logic [PtrW-1:0] tail, idx;
  logic [PtrW:0]   count;
  logic            full, empty, push, drain;
  logic            load_req, store_req, hit, covered, fwd, stall, load_port;
  logic [3:0]      need_mask, emask, hit_mask;
  sb_entry_t       hit_ent;
  logic [BYTE_WIDTH-1:0] fwd_byte;
  logic            yield_q;

  assign load_req   = req_valid_i & ~req_we_i;
  assign store_req  = req_valid_i & req_we_i;
  assign need_mask  = byte_mask(req_byte_i, req_addr_i[1:0]);
  assign push_entry = '{addr: req_addr_i, is_byte: req_byte_i, data: req_wd_i};

  // Walk oldest to youngest so the youngest overlapping entry is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_ent  = '0;
    hit_mask = '0;
    idx      = '0;
    emask    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k <= int'(count)) begin
        idx   = tail - PtrW'(k);
        emask = byte_mask(entries[idx].is_byte, entries[idx].addr[1:0]);
        if (entries[idx].addr[SB_DW-1:2] == req_addr_i[DATA_WIDTH-1:2] &&
            (emask & need_mask) != 4'h0) begin
          hit      = 1'b1;
          hit_ent  = entries[idx];
          hit_mask = emask;
        end
      end
    end
  end

  assign covered   = ((hit_mask & need_mask) == need_mask);
  assign fwd       = load_req & hit & covered;
  assign stall     = load_req & hit & ~covered;
  // A stalled load hands the port to the drain every other cycle so it cannot deadlock.
  assign load_port = load_req & ~fwd & ~(stall & yield_q);
  assign drain     = (count != '0) & ~load_port;
  assign push      = store_req & (~full | drain);

  assign req_ready_o = ~(stall | (store_req & full & ~drain));

  // Byte entries hold their byte in [7:0]; word entries are indexed by the load offset.
  assign fwd_byte = hit_ent.is_byte ? hit_ent.data[BYTE_WIDTH-1:0]
                  : hit_ent.data[int'(req_addr_i[1:0]) * int'(BYTE_WIDTH) +: BYTE_WIDTH];

  always_comb begin
    rd_o = '0;
    if (rst_n && load_req) begin
      if (fwd) begin
        rd_o = req_byte_i ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, fwd_byte} : hit_ent.data;
      end else begin
        rd_o = mem_rd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) yield_q <= 1'b0;
    else        yield_q <= stall ? ~yield_q : 1'b0;
  end

  assign mem_we_o      = drain;
  assign mem_addr_o    = drain ? head.addr : req_addr_i;
  assign mem_byte_op_o = drain ? head.is_byte : req_byte_i;
  assign mem_wd_o      = drain ? head.data : '0;
  assign empty_o       = empty;

  sb_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (drain),
    .head_o      (head),
    .entries_o   (entries),
    .tail_o      (tail),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small byte-addressable data_memory model.
module tb_store_buffer;

  logic        clk, rst_n;
  logic        req_valid_i, req_we_i, req_byte_i;
  logic [31:0] req_addr_i, req_wd_i;
  logic        req_ready_o, empty_o, mem_we_o, mem_byte_op_o;
  logic [31:0] rd_o, mem_addr_o, mem_wd_o, mem_rd_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem [64];
  logic [31:0] rd_word;

  store_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_byte_i   (req_byte_i),
    .req_addr_i   (req_addr_i),
    .req_wd_i     (req_wd_i),
    .req_ready_o  (req_ready_o),
    .rd_o         (rd_o),
    .empty_o      (empty_o),
    .mem_we_o     (mem_we_o),
    .mem_byte_op_o(mem_byte_op_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: falling-edge write, combinational read
  always @(negedge clk) begin
    if (mem_we_o) begin
      if (mem_byte_op_o) dmem[mem_addr_o[7:2]][{mem_addr_o[1:0], 3'b000} +: 8] <= mem_wd_o[7:0];
      else               dmem[mem_addr_o[7:2]] <= mem_wd_o;
    end
  end

  always_comb begin
    rd_word  = dmem[mem_addr_o[7:2]];
    mem_rd_i = mem_byte_op_o ? {24'h0, rd_word[{mem_addr_o[1:0], 3'b000} +: 8]} : rd_word;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic we, input logic b,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid_i = v;
    req_we_i    = we;
    req_byte_i  = b;
    req_addr_i  = a;
    req_wd_i    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    rst_n = 1'b0;
    req(1'b1, 1'b0, 1'b0, 32'h10004, 32'h0);
    #2;
    chk("rst_empty", empty_o, 1);
    chk("rst_we", mem_we_o, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_rd", rd_o, 0);
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW then LW to same address: forwarded, store drains in the same cycle
    tick(); req(1, 1, 0, 32'h10004, 32'hDEADBEEF); #3;
    chk("sw_ready", req_ready_o, 1);
    chk("sw_no_drain", mem_we_o, 0);
    tick(); req(1, 0, 0, 32'h10004, 32'h0); #3;
    chk("lw_fwd_rd", rd_o, 32'hDEADBEEF);
    chk("lw_fwd_ready", req_ready_o, 1);
    chk("lw_fwd_drain_we", mem_we_o, 1);
    chk("lw_fwd_drain_addr", mem_addr_o, 32'h10004);
    tick(); req(0, 0, 0, 32'h0, 32'h0); #3;
    chk("t2_empty", empty_o, 1);
    chk("t2_mem", dmem[6'h01], 32'hDEADBEEF);

    // Byte forwarding out of a word entry, then from a byte entry
    tick(); req(1, 1, 0, 32'h10008, 32'h11223344); #3;
    tick(); req(1, 0, 1, 32'h1000A, 32'h0); #3;
    chk("lbu_from_word", rd_o, 32'h00000022);
    chk("lbu_from_word_ready", req_ready_o, 1);
    tick(); req(1, 1, 1, 32'h1000A, 32'h000000AB); #3;
    chk("sb_ready", req_ready_o, 1);
    tick(); req(1, 0, 1, 32'h1000A, 32'h0); #3;
    chk("lbu_youngest", rd_o, 32'h000000AB);
    tick(); req(0, 0, 0, 32'h0, 32'h0); #3;
    chk("t3_empty", empty_o, 1);
    // Misses read through to memory
    tick(); req(1, 0, 0, 32'h10008, 32'h0); #3;
    chk("lw_miss_rd", rd_o, 32'h11AB3344);
    chk("lw_miss_we", mem_we_o, 0);
    chk("lw_miss_addr", mem_addr_o, 32'h10008);
    tick(); req(1, 0, 1, 32'h10009, 32'h0); #3;
    chk("lbu_miss_rd", rd_o, 32'h00000033);
    chk("lbu_miss_byteop", mem_byte_op_o, 1);

    // Word load over byte entry stalls until the byte drains
    tick(); req(1, 1, 1, 32'h10010, 32'h00000055); #3;
    tick(); req(1, 0, 0, 32'h10010, 32'h0); #3;
    chk("stall_c1_ready", req_ready_o, 0);
    chk("stall_c1_we", mem_we_o, 0);
    tick(); #3;
    chk("stall_c2_ready", req_ready_o, 0);
    chk("stall_c2_we", mem_we_o, 1);
    chk("stall_c2_addr", mem_addr_o, 32'h10010);
    chk("stall_c2_byteop", mem_byte_op_o, 1);
    chk("stall_c2_wd", mem_wd_o & 32'hFF, 32'h55);
    tick(); #3;
    chk("stall_c3_ready", req_ready_o, 1);
    chk("stall_c3_rd", rd_o, 32'h00000055);

    // Back-to-back stores: never stall, drain in program order
    for (int i = 0; i < 5; i++) begin
      tick(); req(1, 1, 0, 32'h10020 + 32'(4 * (i % 4)), 32'hA0 + 32'(i)); #3;
      chk("fill_ready", req_ready_o, 1);
      if (i > 0) chk("fill_drain_wd", mem_wd_o, 32'hA0 + 32'(i - 1));
    end
    tick(); req(0, 0, 0, 32'h0, 32'h0); #3;
    chk("fill_last_wd", mem_wd_o, 32'hA4);
    tick(); #3;
    chk("fill_empty", empty_o, 1);
    chk("fill_mem0", dmem[6'h08], 32'hA4);
    chk("fill_mem1", dmem[6'h09], 32'hA1);
    chk("fill_mem3", dmem[6'h0B], 32'hA3);

    // Two stores to the same word: A drains before B, B survives
    tick(); req(1, 1, 0, 32'h10030, 32'h0A0A0A0A); #3;
    tick(); req(1, 1, 0, 32'h10030, 32'h0B0B0B0B); #3;
    chk("order_a", mem_wd_o, 32'h0A0A0A0A);
    tick(); req(0, 0, 0, 32'h0, 32'h0); #3;
    chk("order_b", mem_wd_o, 32'h0B0B0B0B);
    tick(); #3;
    chk("order_mem", dmem[6'h0C], 32'h0B0B0B0B);

    // Reset in the middle of a drain cycle kills the write
    tick(); req(1, 1, 0, 32'h10040, 32'h77777777); #3;
    tick(); req(0, 0, 0, 32'h0, 32'h0); #1;
    chk("mid_drain_we", mem_we_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    tick();
    rst_n = 1'b1;
    tick(); #3;
    chk("mid_rst_mem", dmem[6'h10], 32'h0);
    chk("mid_rst_post_we", mem_we_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
